// File: rtl/daq_mode_ctrl.sv
// DAQ run sequencer: power pulsing, ASIC reset, acquisition window, hold,
// readout handshake and end-of-run drain for AUTO / SLAVE / COUNT modes.
module daq_mode_ctrl #(
  parameter int unsigned TIME_W   = 16,
  parameter int unsigned CHIP_NUM = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TICK_DIV = 40
) (
  input  logic                Clk,
  input  logic                SlaveDaq_ResetUsbStart_n,
  input  logic [1:0]          DaqMode,
  input  logic                UsbAcqStart,
  input  logic                ExternalTrigger,
  input  logic [CHIP_NUM-1:0] CHIPSATB,
  input  logic                EndReadout,
  input  logic                DataTransmitDone,
  input  logic                UsbFifoEmpty,
  input  logic [TIME_W-1:0]   AcquisitionTime,
  input  logic [TIME_W-1:0]   EndHoldTime,
  input  logic [CNT_W-1:0]    AcqCount,
  output logic                RESET_B,
  output logic                START_ACQ,
  output logic [3:0]          PWR_ON,
  output logic                StartReadout,
  output logic                OnceEnd,
  output logic                AllDone,
  output logic                UsbStartStop,
  output logic [CNT_W-1:0]    AcqIndex
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] MODE_AUTO  = 2'd0;
  localparam logic [1:0] MODE_COUNT = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  localparam logic [3:0] PWR_ALL     = 4'hF;
  localparam logic [3:0] PWR_DIGITAL = 4'b0100;

  typedef enum logic [3:0] {
    S_IDLE, S_PWR_UP, S_RST, S_ARM, S_ACQ, S_HOLD, S_READ, S_WAIT_END, S_ONCE, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q;
  logic               usb_q;
  logic [2:0]         trig_sync_q;
  logic               stop_q;
  logic [DIV_W-1:0]   div_q;
  logic [TIME_W-1:0]  ticks_q;
  logic [1:0]         rst_cnt_q;

  logic               usb_rise_c, usb_fall_c, trig_edge_c, stop_pend_c;
  logic               tick_c, acq_exp_c, hold_exp_c, chip_full_c, count_hit_c;
  logic [TIME_W-1:0]  acq_last_c;

  logic               reset_b_d, start_acq_d, start_readout_d, once_end_d;
  logic               all_done_d, usb_ss_d;
  logic [3:0]         pwr_on_d;
  logic [CNT_W-1:0]   acq_index_d;

  // Edge detection and window timing
  always_comb begin
    usb_rise_c  = UsbAcqStart & ~usb_q;
    usb_fall_c  = ~UsbAcqStart & usb_q;
    trig_edge_c = trig_sync_q[1] & ~trig_sync_q[2];
    stop_pend_c = stop_q | usb_fall_c;
    tick_c      = (div_q == DIV_W'(TICK_DIV - 1));
    acq_last_c  = (AcquisitionTime == '0) ? '0 : AcquisitionTime - TIME_W'(1);
    acq_exp_c   = tick_c && (ticks_q >= acq_last_c);
    hold_exp_c  = tick_c && ((EndHoldTime == '0) || (ticks_q >= EndHoldTime - TIME_W'(1)));
    chip_full_c = ~(&CHIPSATB);
    count_hit_c = (mode_q == MODE_COUNT) && (AcqCount != '0) &&
                  ((AcqIndex + CNT_W'(1)) == AcqCount);
  end

  // Next state and next registered output values
  always_comb begin
    state_d     = state_q;
    pwr_on_d    = PWR_ON;
    all_done_d  = AllDone;
    usb_ss_d    = UsbStartStop;
    acq_index_d = AcqIndex;

    case (state_q)
      S_IDLE: begin
        if (usb_rise_c && (DaqMode != MODE_RSVD)) begin
          state_d     = S_PWR_UP;
          usb_ss_d    = 1'b1;
          acq_index_d = '0;
        end
      end
      S_PWR_UP:   if (tick_c) state_d = S_RST;
      S_RST:      if (rst_cnt_q == 2'd3) state_d = S_ARM;
      S_ARM: begin
        if (stop_pend_c)                                state_d = S_DONE;
        else if ((mode_q == MODE_AUTO) || trig_edge_c) state_d = S_ACQ;
      end
      S_ACQ: begin
        if (acq_exp_c || chip_full_c)
          state_d = (EndHoldTime == '0) ? S_READ : S_HOLD;
      end
      S_HOLD:     if (hold_exp_c) state_d = S_READ;
      S_READ:     state_d = S_WAIT_END;
      S_WAIT_END: if (EndReadout) state_d = S_ONCE;
      S_ONCE: begin
        acq_index_d = AcqIndex + CNT_W'(1);
        if (stop_pend_c || count_hit_c) state_d = S_DONE;
        else if (mode_q == MODE_AUTO)   state_d = S_PWR_UP;
        else                            state_d = S_ARM;
      end
      S_DONE: begin
        if (DataTransmitDone)               all_done_d = 1'b1;
        if (AllDone && UsbFifoEmpty)        usb_ss_d   = 1'b0;
        if (!UsbStartStop && !UsbAcqStart)  state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) all_done_d = 1'b0;

    // Analog supplies stay down to digital-only from readout until the next power-up
    case (state_d)
      S_PWR_UP:       pwr_on_d = PWR_ALL;
      S_READ:         pwr_on_d = PWR_DIGITAL;
      S_IDLE, S_DONE: pwr_on_d = 4'h0;
      default:        pwr_on_d = PWR_ON;
    endcase

    reset_b_d       = (state_d != S_RST);
    start_acq_d     = (state_d == S_ACQ);
    start_readout_d = (state_d == S_READ);
    once_end_d      = (state_d == S_ONCE);
  end

  // State, timing and output registers
  always_ff @(posedge Clk or negedge SlaveDaq_ResetUsbStart_n) begin
    if (!SlaveDaq_ResetUsbStart_n) begin
      state_q      <= S_IDLE;
      mode_q       <= MODE_AUTO;
      usb_q        <= 1'b0;
      trig_sync_q  <= '0;
      stop_q       <= 1'b0;
      div_q        <= '0;
      ticks_q      <= '0;
      rst_cnt_q    <= '0;
      RESET_B      <= 1'b1;
      START_ACQ    <= 1'b0;
      PWR_ON       <= 4'h0;
      StartReadout <= 1'b0;
      OnceEnd      <= 1'b0;
      AllDone      <= 1'b0;
      UsbStartStop <= 1'b0;
      AcqIndex     <= '0;
    end else begin
      state_q     <= state_d;
      usb_q       <= UsbAcqStart;
      trig_sync_q <= {trig_sync_q[1:0], ExternalTrigger};

      if (state_q == S_IDLE) begin
        stop_q <= 1'b0;
        if (usb_rise_c) mode_q <= DaqMode;
      end else if (usb_fall_c) begin
        stop_q <= 1'b1;
      end

      // Prescaler and tick count restart on every state entry
      if (state_d != state_q) begin
        div_q     <= '0;
        ticks_q   <= '0;
        rst_cnt_q <= '0;
      end else begin
        rst_cnt_q <= rst_cnt_q + 2'd1;
        if (tick_c) begin
          div_q   <= '0;
          ticks_q <= ticks_q + TIME_W'(1);
        end else begin
          div_q   <= div_q + DIV_W'(1);
        end
      end

      RESET_B      <= reset_b_d;
      START_ACQ    <= start_acq_d;
      PWR_ON       <= pwr_on_d;
      StartReadout <= start_readout_d;
      OnceEnd      <= once_end_d;
      AllDone      <= all_done_d;
      UsbStartStop <= usb_ss_d;
      AcqIndex     <= acq_index_d;
    end
  end

endmodule

// File: doc/daq_mode_ctrl.md
DAQ_MODE_CTRL -- requirements
Module: daq_mode_ctrl

Interface
REQ-001 Parameter TIME_W, default 16: width of AcquisitionTime and EndHoldTime.
REQ-002 Parameter CHIP_NUM, default 4: number of daisy-chained ASICs, which is the CHIPSATB width.
REQ-003 Parameter CNT_W, default 16: width of AcqCount and AcqIndex.
REQ-004 Parameter TICK_DIV, default 40: Clk cycles per time tick (1 us at 40 MHz).
REQ-005 Clk  in  1  system clock; all logic rising-edge.
REQ-006 SlaveDaq_ResetUsbStart_n  in  1  reset, asynchronous, active-low; clock Clk.
REQ-007 DaqMode  in  2  0=AUTO, 1=SLAVE, 2=COUNT, 3=reserved.
REQ-008 UsbAcqStart  in  1  run request level; rising edge starts, falling edge requests stop.
REQ-009 ExternalTrigger  in  1  asynchronous trigger; 2-FF synchronised, then rising-edge detected.
REQ-010 CHIPSATB  in  CHIP_NUM  per-chip RAM full, active-low.
REQ-011 EndReadout  in  1  readout finished, active-high.
REQ-012 DataTransmitDone  in  1  downstream data path drained.
REQ-013 UsbFifoEmpty  in  1  USB FIFO empty.
REQ-014 AcquisitionTime  in  TIME_W  acquisition window, in ticks.
REQ-015 EndHoldTime  in  TIME_W  post-acquisition hold, in ticks.
REQ-016 AcqCount  in  CNT_W  COUNT-mode acquisition target; 0 = unlimited.
REQ-017 RESET_B  out  1  ASIC digital reset, active-low.
REQ-018 START_ACQ  out  1  ASIC acquisition enable.
REQ-019 PWR_ON  out  4  power pulsing {A,D,ADC,DAC}, active-high.
REQ-020 StartReadout  out  1  single-cycle readout start pulse.
REQ-021 OnceEnd  out  1  single-cycle pulse at the end of each acquisition cycle.
REQ-022 AllDone  out  1  run complete level.
REQ-023 UsbStartStop  out  1  USB streaming enable, registered on Clk.
REQ-024 AcqIndex  out  CNT_W  count of completed cycles in the current run.

Function
REQ-025 FSM states: IDLE, PWR_UP, RST, ARM, ACQ, HOLD, READ, WAIT_END, ONCE, DONE.
REQ-026 IDLE: on the UsbAcqStart rising edge, the block latches DaqMode; if the mode is 0-2 it moves to PWR_UP next cycle and sets UsbStartStop, and AcqIndex clears to 0; if the mode is 3 the edge is ignored. DaqMode changes mid-run are ignored.
REQ-027 PWR_UP: PWR_ON=4'hF, held for 1 tick, then go to RST.
REQ-028 RST: RESET_B=0 for exactly 4 Clk cycles, then go to ARM.
REQ-029 ARM: AUTO goes to ACQ next cycle; SLAVE/COUNT wait for a synchronised trigger edge and enter ACQ on the following cycle; a pending stop request in ARM goes to DONE.
REQ-030 ACQ: START_ACQ=1; leave when the AcquisitionTime ticks expire or any CHIPSATB bit is 0 (full), whichever comes first; AcquisitionTime=0 is treated as 1 tick.
REQ-031 HOLD: START_ACQ=0 for EndHoldTime ticks; EndHoldTime=0 skips HOLD and goes directly to READ.
REQ-032 READ: StartReadout=1 for one cycle; PWR_ON drops to 4'b0100 (digital only) from here until the next PWR_UP.
REQ-033 WAIT_END: wait for EndReadout=1, then go to ONCE.
REQ-034 ONCE: OnceEnd=1 for one cycle and AcqIndex increments, wrapping at 2^CNT_W.
- Go to DONE if a stop is pending or (COUNT mode and AcqCount!=0 and AcqIndex+1==AcqCount).
- Otherwise AUTO goes to PWR_UP and SLAVE/COUNT go to ARM.
REQ-035 Stop request: the UsbAcqStart falling edge sets a sticky flag. The current cycle always completes through ONCE; the flag is never honoured inside ACQ or WAIT_END.
REQ-036 DONE: PWR_ON=0 and AllDone=1 from the first cycle DataTransmitDone=1 onward.
- UsbStartStop clears on the cycle after AllDone&&UsbFifoEmpty.
- Return to IDLE when UsbStartStop=0 and UsbAcqStart=0; AllDone clears on that transition.
REQ-037 Triggers are not queued: edges outside ARM are dropped.
REQ-038 Tick prescaler: restarts at 0 on every state entry, and a tick completes after TICK_DIV cycles.

Reset
REQ-039 On reset assertion, all outputs take their reset values immediately, with no Clk required: RESET_B=1, START_ACQ=0, PWR_ON=0, StartReadout=0, OnceEnd=0, AllDone=0, UsbStartStop=0, AcqIndex=0. State=IDLE, stop flag and synchronisers cleared.
REQ-040 Release is synchronous to Clk. A reset asserted mid-run abandons the run; no OnceEnd is issued.

Verification
REQ-041 AUTO with AcquisitionTime=3, EndHoldTime=0, TICK_DIV=4: START_ACQ high 12 cycles, StartReadout 1 cycle after; EndReadout -> OnceEnd, new PWR_UP.
REQ-042 COUNT with AcqCount=3 and 3 triggers: 3 OnceEnd pulses, AcqIndex=3, DONE; AllDone after DataTransmitDone; UsbStartStop falls once UsbFifoEmpty=1.
REQ-043 SLAVE, CHIPSATB=4'b1101 asserted on the second tick of AcquisitionTime=100: START_ACQ drops by the next cycle and HOLD is entered.
REQ-044 Drop UsbAcqStart during ACQ: the cycle completes (OnceEnd=1), then DONE; a trigger during ACQ is ignored and AcqIndex increments by 1 only.
REQ-045 Assert reset during WAIT_END: all outputs reach their reset values immediately; DaqMode=3 with a start edge stays in IDLE.
